// File: rtl/battle_pkg.sv
// Shared definitions for the battle engine: default widths, result codes and FSM states.
package battle_pkg;

  localparam int HP_W_DEF      = 10;
  localparam int ATK_W_DEF     = 7;
  localparam int COIN_W_DEF    = 7;
  localparam int N_ENEMY_DEF   = 5;
  localparam int ID_W_DEF      = 3;
  localparam int TICK_LOG2_DEF = 24;
  localparam int RND_W_DEF     = 8;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_WIN   = 2'b01;
  localparam logic [1:0] RES_LOSE  = 2'b10;
  localparam logic [1:0] RES_ABORT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FIGHT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/battle_dmg_calc.sv
// One strike: damage = max(atk - def, 0) widened to HP width, then HP reduced with a floor at 0.
module battle_dmg_calc #(
  parameter int HP_W  = 10,
  parameter int ATK_W = 7
) (
  input  logic [ATK_W-1:0] atk,
  input  logic [ATK_W-1:0] def,
  input  logic [HP_W-1:0]  hp,
  output logic [HP_W-1:0]  hp_next,
  output logic             blocked
);

  logic [ATK_W-1:0] diff;
  logic [HP_W-1:0]  dmg;

  always_comb begin
    diff = '0;
    if (atk > def) diff = atk - def;
    dmg     = HP_W'(diff);
    blocked = (diff == '0);
    hp_next = (hp <= dmg) ? '0 : hp - dmg;
  end

endmodule

// File: rtl/battle_engine.sv
// Turn-based combat resolver: loads hero and enemy stats, resolves one round per tick,
// and reports win/lose/abort with remaining HP, coins and rounds fought.
module battle_engine
  import battle_pkg::*;
#(
  parameter int HP_W      = HP_W_DEF,
  parameter int ATK_W     = ATK_W_DEF,
  parameter int COIN_W    = COIN_W_DEF,
  parameter int N_ENEMY   = N_ENEMY_DEF,
  parameter int ID_W      = ID_W_DEF,
  parameter int TICK_LOG2 = TICK_LOG2_DEF,
  parameter int RND_W     = RND_W_DEF
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [ID_W-1:0]   enemy_sel,
  input  logic [HP_W-1:0]   hero_hp_in,
  input  logic [ATK_W-1:0]  hero_atk,
  input  logic [ATK_W-1:0]  hero_def,
  input  logic              tbl_we,
  input  logic [ID_W-1:0]   tbl_idx,
  input  logic [HP_W-1:0]   tbl_hp,
  input  logic [ATK_W-1:0]  tbl_atk,
  input  logic [ATK_W-1:0]  tbl_def,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result,
  output logic [HP_W-1:0]   hero_hp_out,
  output logic [HP_W-1:0]   enemy_hp_out,
  output logic [COIN_W-1:0] coins_gained,
  output logic [RND_W-1:0]  round_cnt
);

  localparam logic [ID_W:0] N_ENEMY_C = (ID_W+1)'(N_ENEMY);

  state_t state_q, state_d;

  logic [HP_W-1:0]  tbl_hp_q  [N_ENEMY];
  logic [HP_W-1:0]  tbl_hp_d  [N_ENEMY];
  logic [ATK_W-1:0] tbl_atk_q [N_ENEMY];
  logic [ATK_W-1:0] tbl_atk_d [N_ENEMY];
  logic [ATK_W-1:0] tbl_def_q [N_ENEMY];
  logic [ATK_W-1:0] tbl_def_d [N_ENEMY];

  logic [HP_W-1:0]      hero_hp_q, hero_hp_d, enemy_hp_q, enemy_hp_d;
  logic [ATK_W-1:0]     hero_atk_q, hero_atk_d, hero_def_q, hero_def_d;
  logic [ATK_W-1:0]     en_atk_q, en_atk_d, en_def_q, en_def_d;
  logic [ID_W-1:0]      sel_q, sel_d;
  logic [1:0]           result_q, result_d;
  logic [COIN_W-1:0]    coins_q, coins_d;
  logic [RND_W-1:0]     round_q, round_d;
  logic [TICK_LOG2-1:0] tick_q, tick_d;

  logic             sel_ok, idx_ok, in_load, tick_fire, load_end, fight_end;
  logic [HP_W-1:0]  row_hp;
  logic [ATK_W-1:0] row_atk, row_def;
  logic [ATK_W-1:0] calc_h_atk, calc_h_def, calc_e_atk, calc_e_def;
  logic [HP_W-1:0]  enemy_hp_nx, hero_hp_nx;
  logic             blocked_h, blocked_e;
  logic [ID_W-1:0]  coin_sel;
  logic [ID_W:0]    sel_inc;
  logic [COIN_W-1:0] coin_val;

  assign sel_ok    = {1'b0, enemy_sel} < N_ENEMY_C;
  assign idx_ok    = {1'b0, tbl_idx} < N_ENEMY_C;
  assign in_load   = (state_q == ST_LOAD);
  assign tick_fire = (state_q == ST_FIGHT) && (tick_q == '1);

  // Out-of-range selections read as an all-zero row; the abort check fires first anyway.
  assign row_hp  = sel_ok ? tbl_hp_q[enemy_sel]  : '0;
  assign row_atk = sel_ok ? tbl_atk_q[enemy_sel] : '0;
  assign row_def = sel_ok ? tbl_def_q[enemy_sel] : '0;

  // During LOAD the strike units see live inputs so the stalemate check can use them.
  assign calc_h_atk = in_load ? hero_atk : hero_atk_q;
  assign calc_h_def = in_load ? row_def  : en_def_q;
  assign calc_e_atk = in_load ? row_atk  : en_atk_q;
  assign calc_e_def = in_load ? hero_def : hero_def_q;

  assign coin_sel = in_load ? enemy_sel : sel_q;
  assign sel_inc  = {1'b0, coin_sel} + 1'b1;
  assign coin_val = COIN_W'(sel_inc);

  battle_dmg_calc #(.HP_W(HP_W), .ATK_W(ATK_W)) u_hero_hit (
    .atk(calc_h_atk), .def(calc_h_def), .hp(enemy_hp_q),
    .hp_next(enemy_hp_nx), .blocked(blocked_h)
  );

  battle_dmg_calc #(.HP_W(HP_W), .ATK_W(ATK_W)) u_enemy_hit (
    .atk(calc_e_atk), .def(calc_e_def), .hp(hero_hp_q),
    .hp_next(hero_hp_nx), .blocked(blocked_e)
  );

  always_comb begin
    tbl_hp_d   = tbl_hp_q;
    tbl_atk_d  = tbl_atk_q;
    tbl_def_d  = tbl_def_q;
    hero_hp_d  = hero_hp_q;
    enemy_hp_d = enemy_hp_q;
    hero_atk_d = hero_atk_q;
    hero_def_d = hero_def_q;
    en_atk_d   = en_atk_q;
    en_def_d   = en_def_q;
    sel_d      = sel_q;
    result_d   = result_q;
    coins_d    = coins_q;
    round_d    = round_q;
    tick_d     = tick_q;
    load_end   = 1'b0;
    fight_end  = 1'b0;

    if (tbl_we && idx_ok) begin
      tbl_hp_d[tbl_idx]  = tbl_hp;
      tbl_atk_d[tbl_idx] = tbl_atk;
      tbl_def_d[tbl_idx] = tbl_def;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d = RES_NONE;
          coins_d  = '0;
          round_d  = '0;
        end
      end
      ST_LOAD: begin
        hero_hp_d  = hero_hp_in;
        hero_atk_d = hero_atk;
        hero_def_d = hero_def;
        enemy_hp_d = row_hp;
        en_atk_d   = row_atk;
        en_def_d   = row_def;
        sel_d      = enemy_sel;
        tick_d     = '0;
        load_end   = 1'b1;
        if (!sel_ok) begin
          result_d = RES_ABORT;
        end else if (row_hp == '0) begin
          result_d = RES_WIN;
          coins_d  = coin_val;
        end else if (hero_hp_in == '0) begin
          result_d = RES_LOSE;
        end else if (blocked_h) begin
          result_d = RES_ABORT;
        end else begin
          load_end = 1'b0;
        end
      end
      ST_FIGHT: begin
        tick_d = tick_q + 1'b1;
        if (tick_fire) begin
          if (round_q != '1) round_d = round_q + 1'b1;
          // Hero strikes first; a killed enemy does not strike back.
          if (enemy_hp_nx == '0) begin
            enemy_hp_d = '0;
            result_d   = RES_WIN;
            coins_d    = coin_val;
            fight_end  = 1'b1;
          end else begin
            enemy_hp_d = enemy_hp_nx;
            hero_hp_d  = hero_hp_nx;
            if (!blocked_e && hero_hp_nx == '0) begin
              result_d  = RES_LOSE;
              fight_end = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = load_end ? ST_DONE : ST_FIGHT;
      ST_FIGHT: if (fight_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_LOAD, ST_FIGHT: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ENEMY; i++) begin
        tbl_hp_q[i]  <= '0;
        tbl_atk_q[i] <= '0;
        tbl_def_q[i] <= '0;
      end
      hero_hp_q  <= '0;
      enemy_hp_q <= '0;
      hero_atk_q <= '0;
      hero_def_q <= '0;
      en_atk_q   <= '0;
      en_def_q   <= '0;
      sel_q      <= '0;
      result_q   <= RES_NONE;
      coins_q    <= '0;
      round_q    <= '0;
      tick_q     <= '0;
    end else begin
      tbl_hp_q   <= tbl_hp_d;
      tbl_atk_q  <= tbl_atk_d;
      tbl_def_q  <= tbl_def_d;
      hero_hp_q  <= hero_hp_d;
      enemy_hp_q <= enemy_hp_d;
      hero_atk_q <= hero_atk_d;
      hero_def_q <= hero_def_d;
      en_atk_q   <= en_atk_d;
      en_def_q   <= en_def_d;
      sel_q      <= sel_d;
      result_q   <= result_d;
      coins_q    <= coins_d;
      round_q    <= round_d;
      tick_q     <= tick_d;
    end
  end

  assign result       = result_q;
  assign hero_hp_out  = hero_hp_q;
  assign enemy_hp_out = enemy_hp_q;
  assign coins_gained = coins_q;
  assign round_cnt    = round_q;

endmodule

// File: tb/tb_battle_engine.sv
// Directed bench for battle_engine with a 4-cycle round period.
module tb_battle_engine;

  localparam int HP_W = 10, ATK_W = 7, COIN_W = 7, N_ENEMY = 5, ID_W = 3, TICK_LOG2 = 2, RND_W = 8;

  logic              clk_100mhz = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ID_W-1:0]   enemy_sel = '0;
  logic [HP_W-1:0]   hero_hp_in = '0;
  logic [ATK_W-1:0]  hero_atk = '0, hero_def = '0;
  logic              tbl_we = 1'b0;
  logic [ID_W-1:0]   tbl_idx = '0;
  logic [HP_W-1:0]   tbl_hp = '0;
  logic [ATK_W-1:0]  tbl_atk = '0, tbl_def = '0;
  logic              busy, done;
  logic [1:0]        result;
  logic [HP_W-1:0]   hero_hp_out, enemy_hp_out;
  logic [COIN_W-1:0] coins_gained;
  logic [RND_W-1:0]  round_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done, n_busy, n_wait;

  battle_engine #(.HP_W(HP_W), .ATK_W(ATK_W), .COIN_W(COIN_W), .N_ENEMY(N_ENEMY),
                  .ID_W(ID_W), .TICK_LOG2(TICK_LOG2), .RND_W(RND_W)) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .start(start), .enemy_sel(enemy_sel),
    .hero_hp_in(hero_hp_in), .hero_atk(hero_atk), .hero_def(hero_def),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_hp(tbl_hp), .tbl_atk(tbl_atk), .tbl_def(tbl_def),
    .busy(busy), .done(done), .result(result), .hero_hp_out(hero_hp_out),
    .enemy_hp_out(enemy_hp_out), .coins_gained(coins_gained), .round_cnt(round_cnt)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic cyc();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_tbl(input int idx, input int hp, input int atk, input int def);
    tbl_we  = 1'b1;
    tbl_idx = ID_W'(idx);
    tbl_hp  = HP_W'(hp);
    tbl_atk = ATK_W'(atk);
    tbl_def = ATK_W'(def);
    cyc();
    tbl_we = 1'b0;
  endtask

  task automatic set_hero(input int sel, input int hp, input int atk, input int def);
    enemy_sel  = ID_W'(sel);
    hero_hp_in = HP_W'(hp);
    hero_atk   = ATK_W'(atk);
    hero_def   = ATK_W'(def);
  endtask

  // Pulse start, leaving the DUT just after the LOAD edge.
  task automatic fire();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic wait_done(input int max_cyc, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!done && n < max_cyc);
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_hero_hp", hero_hp_out, 0);
    chk("rst_round", round_cnt, 0);
    rst = 1'b0;
    cyc();

    // Win: 20/7/4 enemy vs hero 100/10/2
    wr_tbl(1, 20, 7, 4);
    set_hero(1, 100, 10, 2);
    start = 1'b1;
    cyc();
    chk("win_load_busy", busy, 1);
    chk("win_load_done", done, 0);
    start = 1'b0;
    cyc();
    chk("win_hero_init", hero_hp_out, 100);
    chk("win_enemy_init", enemy_hp_out, 20);
    repeat (4) cyc();
    chk("win_r1_enemy", enemy_hp_out, 14);
    chk("win_r1_hero", hero_hp_out, 95);
    chk("win_r1_round", round_cnt, 1);
    repeat (4) cyc();
    chk("win_r2_enemy", enemy_hp_out, 8);
    chk("win_r2_hero", hero_hp_out, 90);
    repeat (4) cyc();
    chk("win_r3_enemy", enemy_hp_out, 2);
    chk("win_r3_hero", hero_hp_out, 85);
    chk("win_r3_done", done, 0);
    repeat (4) cyc();
    chk("win_done", done, 1);
    chk("win_busy", busy, 1);
    chk("win_result", result, 1);
    chk("win_round", round_cnt, 4);
    chk("win_hero", hero_hp_out, 85);
    chk("win_enemy", enemy_hp_out, 0);
    chk("win_coins", coins_gained, 2);
    cyc();
    chk("win_after_done", done, 0);
    chk("win_after_busy", busy, 0);
    chk("win_hold_result", result, 1);

    // Lose: 100/6/0 enemy vs hero 10/10/0
    wr_tbl(0, 100, 6, 0);
    set_hero(0, 10, 10, 0);
    start = 1'b1;
    cyc();
    chk("lose_clr_result", result, 0);
    chk("lose_clr_coins", coins_gained, 0);
    chk("lose_clr_round", round_cnt, 0);
    start = 1'b0;
    cyc();
    repeat (4) cyc();
    chk("lose_r1_enemy", enemy_hp_out, 90);
    chk("lose_r1_hero", hero_hp_out, 4);
    repeat (4) cyc();
    chk("lose_done", done, 1);
    chk("lose_result", result, 2);
    chk("lose_round", round_cnt, 2);
    chk("lose_hero", hero_hp_out, 0);
    chk("lose_enemy", enemy_hp_out, 80);
    chk("lose_coins", coins_gained, 0);
    cyc();

    // Stalemate: hero atk 4 vs enemy def 5
    wr_tbl(2, 50, 3, 5);
    set_hero(2, 30, 4, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("stale_load_done", done, 0);
    cyc();
    chk("stale_done", done, 1);
    chk("stale_result", result, 3);
    chk("stale_round", round_cnt, 0);
    chk("stale_enemy", enemy_hp_out, 50);
    cyc();

    // Invalid enemy index
    set_hero(6, 30, 10, 0);
    fire();
    chk("inv_done", done, 1);
    chk("inv_result", result, 3);
    chk("inv_round", round_cnt, 0);
    cyc();

    // Empty row (HP 0) wins at LOAD with coins sel+1
    set_hero(3, 10, 5, 0);
    fire();
    chk("empty_done", done, 1);
    chk("empty_result", result, 1);
    chk("empty_coins", coins_gained, 4);
    cyc();

    // Hero starting at 0 HP loses at LOAD
    set_hero(1, 0, 10, 2);
    fire();
    chk("dead_done", done, 1);
    chk("dead_result", result, 2);
    chk("dead_coins", coins_gained, 0);
    cyc();

    // Handshake with start held/re-pulsed; same-cycle write to the active row, write to idx 7
    set_hero(1, 100, 10, 2);
    start = 1'b1;
    cyc();
    tbl_we  = 1'b1;
    tbl_idx = 3'd1;
    tbl_hp  = 10'd12;
    tbl_atk = 7'd12;
    tbl_def = 7'd8;
    cyc();
    tbl_we = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int k = 1; k <= 16; k++) begin
      start   = (k % 3 != 0);
      tbl_we  = (k == 5);
      tbl_idx = 3'd7;
      tbl_hp  = 10'd1;
      tbl_atk = 7'd1;
      tbl_def = 7'd1;
      cyc();
      if (done) n_done++;
      if (busy) n_busy++;
    end
    tbl_we = 1'b0;
    start  = 1'b1;
    chk("hs_one_done", n_done, 1);
    chk("hs_busy_cycles", n_busy, 16);
    chk("hs_old_result", result, 1);
    chk("hs_old_hero", hero_hp_out, 85);
    chk("hs_old_round", round_cnt, 4);
    cyc();
    chk("hs_idle_busy", busy, 0);
    chk("hs_idle_done", done, 0);
    cyc();
    chk("hs_restart_busy", busy, 1);
    chk("hs_restart_result", result, 0);
    start = 1'b0;
    wait_done(40, n_wait);
    chk("new_latency", n_wait, 25);
    chk("new_done", done, 1);
    chk("new_result", result, 1);
    chk("new_round", round_cnt, 6);
    chk("new_hero", hero_hp_out, 50);
    chk("new_enemy", enemy_hp_out, 0);
    chk("new_coins", coins_gained, 2);
    cyc();

    // Reset mid-fight
    set_hero(1, 100, 10, 2);
    fire();
    repeat (6) cyc();
    chk("mid_round", round_cnt, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hero", hero_hp_out, 0);
    chk("arst_enemy", enemy_hp_out, 0);
    chk("arst_round", round_cnt, 0);
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (done) n_done++;
    end
    rst = 1'b0;
    cyc();
    if (done) n_done++;
    chk("arst_no_done", n_done, 0);

    // Table was cleared by reset: row 1 now has HP 0
    set_hero(1, 100, 10, 2);
    fire();
    chk("clr_done", done, 1);
    chk("clr_result", result, 1);
    chk("clr_enemy", enemy_hp_out, 0);
    cyc();

    // Reloaded table fights normally
    wr_tbl(0, 100, 6, 0);
    set_hero(0, 10, 10, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(20, n_wait);
    chk("rl_latency", n_wait, 9);
    chk("rl_result", result, 2);
    chk("rl_round", round_cnt, 2);
    chk("rl_enemy", enemy_hp_out, 80);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/battle_engine.md
Name: battle_engine

Overview:
Parametrised turn-based combat resolver for the dungeon game core. It is the successor to the inline battle logic in the top-level game FSM. The game FSM starts a fight with a start/enemy_sel handshake. The block runs one round per tick from a runtime-writable enemy stat table, then reports win, lose or abort, the remaining HP and the coins earned. New over the inline version: parametrised widths and table depth, a writable table, hero-death detection, stalemate detection, a round counter and a done handshake.

Parameters:
HP_W, 10, hero/enemy HP width
ATK_W, 7, attack width (defence shares it)
COIN_W, 7, coin reward width
N_ENEMY, 5, enemy table depth
ID_W, 3, enemy index width (2^ID_W >= N_ENEMY)
TICK_LOG2, 24, round period = 2^TICK_LOG2 clocks
RND_W, 8, round counter width

Ports:
clk_100mhz  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  fight request, sampled in IDLE only
enemy_sel  in  ID_W  enemy table index
hero_hp_in  in  HP_W  hero HP at start
hero_atk  in  ATK_W  hero attack
hero_def  in  ATK_W  hero defence
tbl_we  in  1  enemy table write enable
tbl_idx  in  ID_W  table write index
tbl_hp  in  HP_W  enemy HP to write
tbl_atk  in  ATK_W  enemy attack to write
tbl_def  in  ATK_W  enemy defence to write
busy  out  1  high from the LOAD cycle until the DONE cycle, inclusive
done  out  1  one-cycle pulse when the fight is resolved
result  out  2  00 none, 01 win, 10 lose, 11 abort
hero_hp_out  out  HP_W  live hero HP
enemy_hp_out  out  HP_W  live enemy HP
coins_gained  out  COIN_W  reward (enemy_sel+1 on win, else 0)
round_cnt  out  RND_W  rounds fought, saturating

Behaviour:
- Reset: all outputs 0, all table rows 0, FSM in IDLE, tick counter 0. Reset mid-fight abandons the fight with no done pulse.
- FSM states: IDLE, LOAD, FIGHT, DONE.
- IDLE:
  - start=1 → LOAD next cycle.
  - On entering LOAD, clear result, coins_gained and round_cnt.
  - start while busy is ignored.
- LOAD (1 cycle):
  - Snapshot hero stats and table row [enemy_sel]; hero_hp_out and enemy_hp_out take the loaded values; clear the tick counter.
  - dmg_h = hero_atk>enemy_def ? hero_atk−enemy_def : 0.
  - dmg_e = enemy_atk>hero_def ? enemy_atk−hero_def : 0.
  - Both computed at ATK_W width and zero-extended to HP_W.
  - Priority, first match wins:
    - enemy_sel >= N_ENEMY → abort.
    - enemy hp = 0 → win.
    - hero hp = 0 → lose.
    - dmg_h = 0 → abort (stalemate).
    - Otherwise → FIGHT.
- FIGHT:
  - Tick counter increments each cycle; a tick fires when it wraps to 0, i.e. the first round resolves 2^TICK_LOG2 cycles after LOAD.
  - On a tick, round_cnt increments (saturating at all-ones).
  - Hero strikes first. If enemy_hp <= dmg_h: enemy_hp becomes 0, result=win, and the enemy does not strike this round.
  - Otherwise enemy_hp −= dmg_h, then hero_hp = hero_hp<=dmg_e ? 0 : hero_hp−dmg_e. If hero_hp becomes 0, result=lose.
  - All of the above is resolved in the tick cycle.
- DONE (1 cycle):
  - done=1 and busy=1; then → IDLE.
  - result, HP outputs, coins_gained and round_cnt hold until the next LOAD.
- coins_gained = enemy_sel+1 (truncated to COIN_W) on win; 0 otherwise.
- Table writes:
  - Accepted in any state.
  - tbl_idx >= N_ENEMY is dropped.
  - A write during a fight does not affect the snapshot in use.
  - A write and a LOAD of the same index in the same cycle: LOAD reads the old value.

Decomposition:
- Shared package battle_pkg holds:
  - result encodings (RES_NONE, RES_WIN, RES_LOSE, RES_ABORT);
  - FSM state enum;
  - default widths, shared with the game FSM and the display.
- Natural sub-module: battle_dmg_calc, a combinational saturating damage and HP-subtract unit, instantiated once per direction.

Test Plan:
All scenarios use TICK_LOG2=2.
- Win: table[1]={20,7,4}; start with sel=1, hero {100,10,2} → dmg 6/5; enemy 14,8,2,0; hero 95,90,85 then unchanged; done with result=01, round_cnt=4, hero_hp_out=85, coins_gained=2.
- Lose: table[0]={100,6,0}; hero {10,10,0} → round1 enemy 90, hero 4; round2 enemy 80, hero 0; result=10, round_cnt=2, coins_gained=0.
- Stalemate/invalid: hero atk 4 vs enemy def 5 → done 2 cycles after start with result=11 and round_cnt=0; sel=6 gives the same response.
- Handshake: start held high and re-pulsed during a fight → exactly one done per fight; busy is high for LOAD through DONE; a new start in the cycle after DONE is accepted.
- Table write during a fight to the active index → the current fight is unchanged; the next fight uses the new values; a write to index 7 is ignored.
- Reset asserted mid-FIGHT → all outputs 0 asynchronously, no done pulse; a subsequent fight with a reloaded table works normally.
